// File: rtl/bks_poly_pkg.sv
// Shared constants and FSM encoding for the GF(2) polynomial datapath.
package bks_poly_pkg;

  localparam int W     = 26;        // divisor / operand width
  localparam int PW    = 2 * W - 1; // dividend / quotient width (51)
  localparam int DEG_W = 5;         // width of a bit index into a W-bit vector
  localparam int CNT_W = 6;         // width of the per-bit iteration counter (0..PW-1)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bks_msb_idx26.sv
// Combinational priority encoder: index of the most significant set bit of a
// 26-bit vector, plus a flag for the all-zero vector (idx is 0 in that case).
module bks_msb_idx26
  import bks_poly_pkg::*;
(
  input  logic [W-1:0]     vec,
  output logic [DEG_W-1:0] idx,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one to write idx.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx  = DEG_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bks26_polydiv.sv
// Sequential GF(2) polynomial divider: dividend (51 bits) / divisor (26 bits)
// yields quotient and remainder with dividend = quotient (x) divisor ^ remainder.
// One dividend bit is consumed per cycle; operands and results move over
// valid/ready handshakes.
module bks26_polydiv
  import bks_poly_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] dividend,
  input  logic [W-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] quotient,
  output logic [W-1:0]  remainder,
  output logic          div_zero
);

  state_t state, state_next;

  logic [PW-1:0]    d_sr;     // dividend bits still to be consumed, MSB first
  logic [W-1:0]     v_reg;    // latched divisor
  logic [W-1:0]     r_win;    // running remainder window
  logic [PW-1:0]    q_sr;     // quotient bits, shifted in at the LSB
  logic [DEG_W-1:0] deg;      // degree of the divisor
  logic [CNT_W-1:0] cnt;      // remaining iterations minus one

  logic [DEG_W-1:0] v_idx;
  logic             v_zero;

  logic [W-1:0]     r_shift;
  logic             q_bit;
  logic [W-1:0]     r_next;
  logic [PW-1:0]    q_next;

  logic             accept;

  bks_msb_idx26 u_msb (
    .vec  (v_reg),
    .idx  (v_idx),
    .zero (v_zero)
  );

  // One long-division step: bring down the next dividend bit and subtract
  // (XOR) the divisor whenever the window reaches the divisor's degree.
  always_comb begin
    r_shift = {r_win[W-2:0], d_sr[PW-1]};
    q_bit   = r_shift[deg];
    r_next  = q_bit ? (r_shift ^ v_reg) : r_shift;
    q_next  = {q_sr[PW-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = NORM;
      end
      NORM: state_next = v_zero ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sr      <= '0;
      v_reg     <= '0;
      r_win     <= '0;
      q_sr      <= '0;
      deg       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            d_sr     <= dividend;
            v_reg    <= divisor;
            r_win    <= '0;
            q_sr     <= '0;
            div_zero <= 1'b0;
          end
        end
        NORM: begin
          if (v_zero) begin
            div_zero  <= 1'b1;
            quotient  <= '0;
            remainder <= '0;
          end else begin
            deg <= v_idx;
            cnt <= CNT_W'(PW - 1);
          end
        end
        RUN: begin
          d_sr  <= {d_sr[PW-2:0], 1'b0};
          r_win <= r_next;
          q_sr  <= q_next;
          cnt   <= cnt - 1'b1;
          // Last bit: publish the completed step directly.
          if (cnt == '0) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bks26_polydiv.sv
// Directed and randomized self-checking bench for bks26_polydiv.
module tb_bks26_polydiv;
  import bks_poly_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_zero;

  int checks = 0;
  int errors = 0;

  bks26_polydiv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry-less multiply (Bks26 reference).
  function automatic logic [127:0] clmul(input logic [63:0] a, input logic [25:0] b);
    logic [127:0] acc;
    acc = '0;
    for (int i = 0; i < 26; i++)
      if (b[i]) acc = acc ^ ({64'b0, a} << i);
    return acc;
  endfunction

  // Textbook long division: clear the top set bit by XORing an aligned divisor.
  function automatic void ref_div(input logic [50:0] n, input logic [25:0] d,
                                  output logic [50:0] q, output logic [25:0] r);
    logic [50:0] rem;
    int dg;
    rem = n;
    q   = '0;
    dg  = 0;
    for (int i = 0; i < 26; i++) if (d[i]) dg = i;
    for (int i = 50; i >= dg; i--) begin
      if (rem[i]) begin
        q[i - dg] = 1'b1;
        rem = rem ^ (51'(d) << (i - dg));
      end
    end
    r = rem[25:0];
  endfunction

  // Present one operand pair, wait for the result; DUT is left in DONE.
  task automatic run_op(input logic [50:0] dvd, input logic [25:0] dvs,
                        output logic [50:0] q, output logic [25:0] r,
                        output logic dz, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("result_arrives", out_valid, 1);
    q  = quotient;
    r  = remainder;
    dz = div_zero;
  endtask

  // Accept the pending result.
  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [50:0] q, eq;
    logic [25:0] r, er;
    logic        dz;
    int          lat;
    int          seen;
    logic [25:0] a, b;
    logic [50:0] n;
    logic [25:0] d;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient",  quotient,  0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero",  div_zero,  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic division and latency.
    run_op(51'hF, 26'h3, q, r, dz, lat);
    check("t1_q", q, 51'h5);
    check("t1_r", r, 0);
    check("t1_dz", dz, 0);
    check("t1_latency", lat, 52);
    retire();

    // Nonzero remainders.
    run_op(51'h1C, 26'h3, q, r, dz, lat);
    check("t2a_q", q, 51'hB);
    check("t2a_r", r, 26'h1);
    retire();
    run_op(51'h8, 26'h7, q, r, dz, lat);
    check("t2b_q", q, 51'h3);
    check("t2b_r", r, 26'h1);
    retire();

    // Degree extremes.
    run_op(51'h7FFFFFFFFFFFF, 26'h1, q, r, dz, lat);
    check("t3a_q", q, 51'h7FFFFFFFFFFFF);
    check("t3a_r", r, 0);
    retire();
    run_op(51'h4000000000000, 26'h2000000, q, r, dz, lat);
    check("t3b_q", q, 51'h2000000);
    check("t3b_r", r, 0);
    check("t3b_latency", lat, 52);
    retire();

    // Zero divisor.
    run_op(51'h123, 26'h0, q, r, dz, lat);
    check("t4_q", q, 0);
    check("t4_r", r, 0);
    check("t4_dz", dz, 1);
    check("t4_latency", lat, 1);
    retire();
    // div_zero clears once the next operands are accepted.
    run_op(51'h8, 26'h7, q, r, dz, lat);
    check("t4_dz_cleared", dz, 0);
    check("t4_next_q", q, 51'h3);
    retire();

    // Backpressure: result held, input ignored.
    run_op(51'h1C, 26'h3, q, r, dz, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 51'h55555;
      divisor  = 26'h5;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_q", quotient,  51'hB);
      check("bp_r", remainder, 26'h1);
    end
    in_valid = 1'b0;
    retire();
    check("bp_hs_out_valid", out_valid, 0);
    check("bp_hs_in_ready",  in_ready,  1);

    // Reset during RUN aborts the operation.
    dividend = 51'hF;
    divisor  = 26'h3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_in_ready",  in_ready,  1);
    check("rr_out_valid", out_valid, 0);
    check("rr_q", quotient,  0);
    check("rr_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rr_no_result", seen, 0);

    // Reset during DONE clears the pending result.
    run_op(51'h123, 26'h0, q, r, dz, lat);
    rst = 1'b1;
    #1;
    check("rd_out_valid", out_valid, 0);
    check("rd_div_zero",  div_zero,  0);
    check("rd_in_ready",  in_ready,  1);
    @(negedge clk);
    rst = 1'b0;

    // Round-trip: Bks26 products divide back exactly.
    for (int i = 0; i < 1000; i++) begin
      a = 26'($urandom);
      b = 26'($urandom);
      if (a == '0) a = 26'h1;
      if (b == '0) b = 26'h3;
      n = clmul({38'b0, a}, b);
      run_op(n, b, q, r, dz, lat);
      check("rt_q", q, {25'b0, a});
      check("rt_r", r, 0);
      check("rt_dz", dz, 0);
      retire();
    end

    // Arbitrary pairs against the reference divider.
    for (int i = 0; i < 100; i++) begin
      n = 51'({$urandom, $urandom});
      d = 26'($urandom) & 26'((64'd1 << $urandom_range(1, 26)) - 1);
      if (d == '0) d = 26'h1;
      ref_div(n, d, eq, er);
      run_op(n, d, q, r, dz, lat);
      check("ref_q", q, eq);
      check("ref_r", r, er);
      check("ref_identity", clmul({13'b0, q}, d) ^ {102'b0, r}, {77'b0, n});
      check("ref_latency", lat, 52);
      retire();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
